// File: rtl/ioports_param.sv
// Byte-serial host I/O port block: N_IN input and N_OUT output ports of DATA_W bits,
// with output readback, per-port auto-return-to-zero and a sticky write-timeout flag.
module ioports_param #(
    parameter int                        N_IN        = 8,
    parameter int                        N_OUT       = 16,
    parameter int                        DATA_W      = 32,
    parameter logic [N_OUT*DATA_W-1:0]   INIT_OUT    = '0,
    parameter logic [15:0]               AZ_MASK     = 16'h8000,
    parameter int                        PULSE_LEN   = 2,
    parameter int                        TIMEOUT_CYC = 1000,
    parameter logic [31:0]               HWID        = 32'h2018_1901
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic                      ready,
    output logic                      enout,
    input  logic [7:0]                datain,
    output logic [7:0]                dataout,
    input  logic [N_IN*DATA_W-1:0]    in_bus,
    output logic [N_OUT*DATA_W-1:0]   out_bus,
    output logic                      busy,
    output logic                      err
);
    localparam int                NB        = DATA_W / 8;
    localparam int                BI_W      = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BI_W-1:0]   BI_LAST   = BI_W'(NB - 1);
    localparam int                TO_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit                TO_EN     = (TIMEOUT_CYC > 0);
    localparam bit                AZ_EN     = (PULSE_LEN > 0);
    localparam logic [7:0]        PULSE_CNT = 8'(PULSE_LEN);

    typedef enum logic [1:0] {S_IDLE, S_WR_BYTE, S_RD_WAIT, S_RD_HOLD} state_t;

    state_t              state_q, state_d;
    logic [3:0]          addr_q, addr_d;
    logic [BI_W-1:0]     byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [TO_W-1:0]     idle_q, idle_d;
    logic                err_q, err_d;
    logic [7:0]          dataout_q, dataout_d;
    logic                enout_q, enout_d;
    logic [DATA_W-1:0]   out_q [N_OUT];
    logic [DATA_W-1:0]   out_d [N_OUT];
    logic [7:0]          azc_q [N_OUT];
    logic [7:0]          azc_d [N_OUT];
    logic [DATA_W-1:0]   wr_word;
    logic                unused_cmd_msb;

    // Opcode is only three bits wide; the command byte MSB carries no meaning.
    assign unused_cmd_msb = datain[7];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        idle_d     = idle_q;
        err_d      = err_q;
        dataout_d  = dataout_q;
        enout_d    = 1'b0;
        wr_word    = (shreg_q << 8) | DATA_W'(datain);
        for (int k = 0; k < N_OUT; k++) begin
            out_d[k] = out_q[k];
            azc_d[k] = azc_q[k];
        end

        // Auto-zero counters tick independently; a commit below overrides them.
        for (int k = 0; k < N_OUT; k++) begin
            if (AZ_EN && AZ_MASK[k] && (azc_q[k] != 8'd0)) begin
                azc_d[k] = azc_q[k] - 8'd1;
                if (azc_q[k] == 8'd1) out_d[k] = '0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    addr_d     = datain[3:0];
                    byte_idx_d = '0;
                    idle_d     = '0;
                    case (datain[6:4])
                        3'b001: begin
                            for (int k = 0; k < N_OUT; k++) begin
                                out_d[k] = INIT_OUT[k*DATA_W +: DATA_W];
                                azc_d[k] = 8'd0;
                            end
                            err_d = 1'b0;
                        end
                        3'b010: begin
                            shreg_d = '0;
                            state_d = S_WR_BYTE;
                        end
                        3'b011: begin
                            shreg_d = HWID[DATA_W-1:0];
                            for (int k = 0; k < N_IN; k++)
                                if (datain[3:0] == 4'(k)) shreg_d = in_bus[k*DATA_W +: DATA_W];
                            state_d = S_RD_WAIT;
                        end
                        3'b100: begin
                            shreg_d = '0;
                            for (int k = 0; k < N_OUT; k++)
                                if (datain[3:0] == 4'(k)) shreg_d = out_q[k];
                            state_d = S_RD_WAIT;
                        end
                        default: ;
                    endcase
                end
            end
            S_WR_BYTE: begin
                if (load) begin
                    shreg_d = wr_word;
                    idle_d  = '0;
                    if (byte_idx_q == BI_LAST) begin
                        // Out-of-range addresses match no port, so the word is dropped.
                        for (int k = 0; k < N_OUT; k++) begin
                            if (addr_q == 4'(k)) begin
                                out_d[k] = wr_word;
                                azc_d[k] = (AZ_EN && AZ_MASK[k]) ? PULSE_CNT : 8'd0;
                            end
                        end
                        state_d = S_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end else if (TO_EN) begin
                    if (idle_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            S_RD_WAIT: begin
                if (ready) begin
                    dataout_d = shreg_q[DATA_W-1 -: 8];
                    shreg_d   = shreg_q << 8;
                    enout_d   = 1'b1;
                    state_d   = S_RD_HOLD;
                end
            end
            S_RD_HOLD: begin
                if (ready) begin
                    enout_d = 1'b1;
                end else if (byte_idx_q == BI_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    state_d    = S_RD_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            idle_q     <= '0;
            err_q      <= 1'b0;
            dataout_q  <= '0;
            enout_q    <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= INIT_OUT[k*DATA_W +: DATA_W];
                azc_q[k] <= 8'd0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
            idle_q     <= idle_d;
            err_q      <= err_d;
            dataout_q  <= dataout_d;
            enout_q    <= enout_d;
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= out_d[k];
                azc_q[k] <= azc_d[k];
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_bus[g*DATA_W +: DATA_W] = out_q[g];
    end

    assign dataout = dataout_q;
    assign enout   = enout_q;
    assign busy    = (state_q != S_IDLE);
    assign err     = err_q;
endmodule

// File: doc/ioports_param.md
Name: ioports_param

Overview:
- Parametrised generation of the byte-serial host I/O port block: N_IN input ports and N_OUT output ports of DATA_W bits each, accessed over the existing 8-bit load/ready/enout byte link.
- Adds readback of output ports, per-port auto-return-to-zero that does not stall the command FSM, and a write-timeout with a sticky error flag.
- Sits between the host byte interface and the datapath control/status registers.

Parameters:
- N_IN, 8: number of input ports, 1..16.
- N_OUT, 16: number of output ports, 1..16.
- DATA_W, 32: port width. Multiple of 8, range 8..32. NB = DATA_W/8 bytes per word.
- INIT_OUT, 0: N_OUT*DATA_W reset/RESET-command value. Port k uses slice [k*DATA_W +: DATA_W].
- AZ_MASK, 16'h8000: bit k=1 gives output port k auto-return-to-zero.
- PULSE_LEN, 2: auto-zero hold length in cycles, 1..255. 0 disables auto-zero globally.
- TIMEOUT_CYC, 1000: maximum idle cycles between write bytes before abort. 0 disables the timeout.
- HWID, 32'h201819_01: value returned for input reads at address >= N_IN. The low DATA_W bits are used.

Ports:
- clk, in, 1: master clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- load, in, 1: datain byte valid, one byte per cycle when high.
- ready, in, 1: host ready to take dataout.
- enout, out, 1: dataout byte valid.
- datain, in, 8: command/data byte.
- dataout, out, 8: read data byte.
- in_bus, in, N_IN*DATA_W: input ports, port k at [k*DATA_W +: DATA_W].
- out_bus, out, N_OUT*DATA_W: output ports, same packing.
- busy, out, 1: FSM not in IDLE.
- err, out, 1: sticky write-timeout flag.

Behaviour:
- Reset (reset_n low, async):
  - out_bus=INIT_OUT, dataout=0, enout=0, err=0, busy=0.
  - All auto-zero counters=0, FSM=IDLE.
  - Reset asserted mid-transaction aborts the transaction immediately; no partial write is committed.
- Command byte, accepted in IDLE with load=1: opcode=datain[6:4], addr=datain[3:0].
  - 001 RESET: same cycle, out_bus=INIT_OUT, counters=0, err=0. Stays in IDLE.
  - 010 WRITE: go to WR_BYTE, byte index=0.
  - 011 READ: snapshot in_bus[addr], or HWID if addr>=N_IN, into shift register. Go to RD_WAIT.
  - 100 READBACK: snapshot out_bus[addr] (current value), or 0 if addr>=N_OUT. Go to RD_WAIT.
  - Any other opcode: ignored, stay in IDLE.
- WR_BYTE:
  - Collect NB bytes, MS byte first, one per load cycle.
  - On the NB-th byte, commit to out_bus[addr] at that clock edge, then return to IDLE. The command byte is followed immediately by data bytes; back-to-back loads are legal.
  - addr>=N_OUT: bytes are consumed and discarded.
  - Idle counter resets on each load. If it reaches TIMEOUT_CYC with no load: abort to IDLE, nothing committed, err=1.
- Read handshake, repeated for NB bytes, MS byte first:
  - RD_WAIT: when ready=1, dataout=next byte, enout=1, go to RD_HOLD; otherwise enout=0.
  - RD_HOLD: enout stays 1 while ready=1. When ready=0, enout=0 and advance; after the last byte go to IDLE.
  - No timeout on reads. load is ignored in read states.
- Auto-zero (port k with AZ_MASK[k]=1 and PULSE_LEN>0):
  - A write commit loads counter k with PULSE_LEN. The port holds the written value for exactly PULSE_LEN cycles after the commit edge, then is cleared to 0 at the edge where the counter reaches 0.
  - A rewrite while counting reloads the counter and value.
  - Counters run independently of the FSM; a new command may be accepted on the cycle after commit.
  - READBACK during the pulse returns the current held value.
- busy=1 in every state except IDLE.

Test Plan:
- Default params. Send 0x25, 0xDE, 0xAD, 0xBE, 0xEF on consecutive cycles -> out_bus[5] = 32'hDEADBEEF from the cycle after the last byte; other ports stay 0.
- in_bus[3]=32'h12345678. Send 0x33, then toggle ready 4 times -> dataout sequence 0x12, 0x34, 0x56, 0x78. enout high only while ready high; busy drops after the 4th ready fall.
- Send 0x2F + 0x00, 0x00, 0x00, 0x07 with PULSE_LEN=2 -> outf=7 for exactly 2 cycles, then 0. A READ command issued the next cycle is accepted during the pulse.
- Send 0x2A, 0x11, then no load for TIMEOUT_CYC cycles -> err=1, FSM in IDLE, out_bus[10] unchanged. A following 0x10 RESET command clears err.
- DATA_W=16, N_OUT=4. Send 0x22, 0xAB, 0xCD, then 0x42 readback -> out_bus[2]=16'hABCD, readback bytes 0xAB, 0xCD. Send 0x29 + 2 bytes -> discarded, no port changes.
- Assert reset_n low after the 2nd byte of a write -> all outputs return to reset values immediately. After release, the next byte is treated as a command in IDLE.
